// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Sits between a UART receiver core and a byte-stream consumer.
//   * Enables the receiver and feeds it a frame-stable copy of the line config.
//   * Classifies each completed frame: parity error, framing error, or good.
//   * Pushes good bytes into a small register FIFO (valid/ready output side).
//   * Counts error frames (saturating) and flags FIFO overflow (sticky).
//   * Emits a one-cycle end-of-message pulse after an idle gap following a byte.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cfg_enable_i                  software receive enable
//   cfg_parity_en_i/_sel_i        requested parity enable / type
//   cfg_stop_bits_i               requested stop bits (0 = one, 1 = two)
//   rx_enable_o                   receiver enable
//   rx_parity_en_o/_sel_o         receiver parity config (frame-stable)
//   rx_stop_bits_o                receiver stop-bit config (frame-stable)
//   rx_data_i, rx_busy_i          receiver data byte / frame-in-progress
//   rx_parity_err_i               receiver parity error indication
//   rx_framing_err_i              receiver framing error indication
//   m_data_o, m_valid_o           FIFO head byte / FIFO not empty
//   m_ready_i                     consumer accepts head byte
//   fifo_level_o                  FIFO occupancy, 0..p_fifo_depth
//   overflow_o                    sticky: good byte dropped on full FIFO
//   clr_i                         clears overflow_o and both error counters
//   parity_cnt_o, framing_cnt_o   saturating error-frame counters
//   timeout_o                     one-cycle idle timeout pulse

module uart_rx_ctrl #(
  parameter int unsigned p_fifo_depth     = 4,
  parameter int unsigned p_timeout_cycles = 1000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_enable_i,
  input  logic                            cfg_parity_en_i,
  input  logic                            cfg_parity_sel_i,
  input  logic                            cfg_stop_bits_i,
  output logic                            rx_enable_o,
  output logic                            rx_parity_en_o,
  output logic                            rx_parity_sel_o,
  output logic                            rx_stop_bits_o,
  input  logic [7:0]                      rx_data_i,
  input  logic                            rx_busy_i,
  input  logic                            rx_parity_err_i,
  input  logic                            rx_framing_err_i,
  output logic [7:0]                      m_data_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [$clog2(p_fifo_depth):0]   fifo_level_o,
  output logic                            overflow_o,
  input  logic                            clr_i,
  output logic [7:0]                      parity_cnt_o,
  output logic [7:0]                      framing_cnt_o,
  output logic                            timeout_o
);

  localparam int unsigned PTR_W = $clog2(p_fifo_depth);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TO_W  = (p_timeout_cycles < 2) ? 1 : $clog2(p_timeout_cycles);

  typedef enum logic [1:0] {
    S_OFF,
    S_ARMED,
    S_RECV,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_enter_recv;
  logic w_commit;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    rx_enable_o  = 1'b0;
    w_enter_recv = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      // A frame already running when we come out of OFF (e.g. after reset)
      // is never tracked: arming waits for the line to go idle.
      S_OFF: begin
        if (cfg_enable_i && !rx_busy_i) begin
          w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        rx_enable_o = 1'b1;
        if (rx_busy_i) begin
          w_next       = S_RECV;
          w_enter_recv = 1'b1;
        end else if (!cfg_enable_i) begin
          w_next = S_OFF;
        end
      end
      S_RECV: begin
        rx_enable_o = cfg_enable_i;
        if (!rx_busy_i) begin
          w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        rx_enable_o = cfg_enable_i;
        w_commit    = 1'b1;
        w_next      = cfg_enable_i ? S_ARMED : S_OFF;
      end
      default: begin
        w_next = S_OFF;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line configuration: tracks cfg only while no frame is in flight
  // ---------------------------------------------------------------------------
  logic r_parity_en;
  logic r_parity_sel;
  logic r_stop_bits;
  logic w_cfg_load;

  assign w_cfg_load = ((r_state == S_OFF) || (r_state == S_ARMED)) && !rx_busy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_parity_en  <= 1'b0;
      r_parity_sel <= 1'b0;
      r_stop_bits  <= 1'b0;
    end else if (w_cfg_load) begin
      r_parity_en  <= cfg_parity_en_i;
      r_parity_sel <= cfg_parity_sel_i;
      r_stop_bits  <= cfg_stop_bits_i;
    end
  end

  assign rx_parity_en_o  = r_parity_en;
  assign rx_parity_sel_o = r_parity_sel;
  assign rx_stop_bits_o  = r_stop_bits;

  // ---------------------------------------------------------------------------
  // Per-frame error flags
  // ---------------------------------------------------------------------------
  logic r_perr;
  logic r_ferr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (w_enter_recv) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (r_state == S_RECV) begin
      if (rx_parity_err_i) begin
        r_perr <= 1'b1;
      end
      if (rx_framing_err_i) begin
        r_ferr <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       r_mem [p_fifo_depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic w_good;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_good  = w_commit && !r_perr && !r_ferr;
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == LVL_W'(p_fifo_depth));
  assign w_pop   = w_valid && m_ready_i;
  // On a full FIFO a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign w_push  = w_good && (!w_full || w_pop);
  assign w_drop  = w_good && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < p_fifo_depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= rx_data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_data_o     = r_mem[r_rd_ptr];
  assign m_valid_o    = w_valid;
  assign fifo_level_o = r_count;

  // ---------------------------------------------------------------------------
  // Overflow flag and error counters (clear beats increment)
  // ---------------------------------------------------------------------------
  logic       r_overflow;
  logic [7:0] r_par_cnt;
  logic [7:0] r_frm_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_overflow <= 1'b0;
      r_par_cnt  <= '0;
      r_frm_cnt  <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_commit && r_perr && (r_par_cnt != '1)) begin
        r_par_cnt <= r_par_cnt + 8'd1;
      end
      if (w_commit && !r_perr && r_ferr && (r_frm_cnt != '1)) begin
        r_frm_cnt <= r_frm_cnt + 8'd1;
      end
    end
  end

  assign overflow_o    = r_overflow;
  assign parity_cnt_o  = r_par_cnt;
  assign framing_cnt_o = r_frm_cnt;

  // ---------------------------------------------------------------------------
  // Idle timeout after the last committed byte
  // ---------------------------------------------------------------------------
  logic            r_to_armed;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // The counter runs 0..p_timeout_cycles-1; the pulse is registered on the
  // increment that would reach p_timeout_cycles, so it appears exactly
  // p_timeout_cycles cycles after the push edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_armed <= 1'b0;
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_push) begin
        r_to_armed <= 1'b1;
        r_to_cnt   <= '0;
      end else if (w_enter_recv) begin
        r_to_armed <= 1'b0;
        r_to_cnt   <= '0;
      end else if (r_to_armed && !rx_busy_i) begin
        if (r_to_cnt == TO_W'(p_timeout_cycles - 1)) begin
          r_timeout  <= 1'b1;
          r_to_armed <= 1'b0;
          r_to_cnt   <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: the receiver core is emulated by driving busy,
// data and error strobes directly. Good bytes are queued as expected values
// when a frame is issued; a monitor pops and compares on every handshake.

module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_enable_i, cfg_parity_en_i, cfg_parity_sel_i, cfg_stop_bits_i;
  logic       rx_enable_o, rx_parity_en_o, rx_parity_sel_o, rx_stop_bits_o;
  logic [7:0] rx_data_i;
  logic       rx_busy_i, rx_parity_err_i, rx_framing_err_i;
  logic [7:0] m_data_o;
  logic       m_valid_o, m_ready_i;
  logic [2:0] fifo_level_o;
  logic       overflow_o, clr_i;
  logic [7:0] parity_cnt_o, framing_cnt_o;
  logic       timeout_o;

  uart_rx_ctrl #(
    .p_fifo_depth     (DEPTH),
    .p_timeout_cycles (TO)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_enable_i     (cfg_enable_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_sel_i (cfg_parity_sel_i),
    .cfg_stop_bits_i  (cfg_stop_bits_i),
    .rx_enable_o      (rx_enable_o),
    .rx_parity_en_o   (rx_parity_en_o),
    .rx_parity_sel_o  (rx_parity_sel_o),
    .rx_stop_bits_o   (rx_stop_bits_o),
    .rx_data_i        (rx_data_i),
    .rx_busy_i        (rx_busy_i),
    .rx_parity_err_i  (rx_parity_err_i),
    .rx_framing_err_i (rx_framing_err_i),
    .m_data_o         (m_data_o),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .fifo_level_o     (fifo_level_o),
    .overflow_o       (overflow_o),
    .clr_i            (clr_i),
    .parity_cnt_o     (parity_cnt_o),
    .framing_cnt_o    (framing_cnt_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted head byte must match the oldest
  // expected byte.
  always @(negedge clk_i) begin
    if (!rst_i && m_valid_o && m_ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=0x%0h expected=none", m_data_o);
      end else begin
        chk("sb_data", {24'd0, m_data_o}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Emulated receiver frame. Returns one step after the edge that starts the
  // first idle cycle (controller in RECV with busy low). flip toggles the
  // requested stop bits mid-frame.
  task automatic frame(input logic [7:0] d, input logic pe, input logic fe,
                       input logic exp_push, input logic flip);
    repeat (3) tick();
    rx_data_i = d;
    rx_busy_i = 1'b1;
    if (exp_push) sb.push_back(d);
    repeat (6) tick();
    if (flip) cfg_stop_bits_i = ~cfg_stop_bits_i;
    rx_parity_err_i  = pe;
    rx_framing_err_i = fe;
    tick();
    rx_parity_err_i  = 1'b0;
    rx_framing_err_i = 1'b0;
    tick();
    rx_busy_i = 1'b0;
  endtask

  initial begin
    int hits;
    int at_k;
    rst_i = 1'b1; clr_i = 1'b0;
    cfg_enable_i = 1'b0; cfg_parity_en_i = 1'b0; cfg_parity_sel_i = 1'b0; cfg_stop_bits_i = 1'b0;
    rx_data_i = 8'h00; rx_busy_i = 1'b0; rx_parity_err_i = 1'b0; rx_framing_err_i = 1'b0;
    m_ready_i = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_enable", rx_enable_o, 0);
    chk("rst_cfg", {rx_parity_en_o, rx_parity_sel_o, rx_stop_bits_o}, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_flags", {overflow_o, timeout_o}, 0);
    chk("rst_cnts", {parity_cnt_o, framing_cnt_o}, 0);

    // 8N1, 0xA5, consumer always ready; then idle timeout
    tick();
    rst_i = 1'b0;
    cfg_enable_i = 1'b1;
    m_ready_i = 1'b1;
    tick(); tick();
    @(negedge clk_i);
    chk("t1_armed", rx_enable_o, 1);
    frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i); chk("t1_valid_recv", m_valid_o, 0);
    @(negedge clk_i); chk("t1_valid_commit", m_valid_o, 0);
    @(negedge clk_i); chk("t1_valid_after", m_valid_o, 1);
    chk("t1_data", m_data_o, 8'hA5);
    hits = 0; at_k = -1;
    for (int k = 1; k <= int'(TO) + 5; k++) begin
      @(negedge clk_i);
      if (k == 1) chk("t1_valid_one_cycle", m_valid_o, 0);
      if (timeout_o) begin hits++; at_k = k; end
    end
    chk("t1_to_hits", hits, 1);
    chk("t1_to_delay", at_k, TO);

    // Parity / framing errors: counted, dropped, no timeout
    cfg_parity_en_i = 1'b1; cfg_parity_sel_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    chk("t2_cfg", {rx_parity_en_o, rx_parity_sel_o}, 2'b10);
    frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    hits = 0;
    for (int k = 0; k < int'(TO) + 5; k++) begin
      @(negedge clk_i);
      if (timeout_o) hits++;
    end
    chk("t2_no_timeout", hits, 0);
    chk("t2_parity_cnt", parity_cnt_o, 1);
    chk("t2_framing_cnt", framing_cnt_o, 0);
    chk("t2_level", fifo_level_o, 0);
    chk("t2_valid", m_valid_o, 0);
    frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("t2_framing_only", {parity_cnt_o, framing_cnt_o}, 16'h0101);
    frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("t2_both_err", {parity_cnt_o, framing_cnt_o}, 16'h0201);
    chk("t2_level_end", fifo_level_o, 0);

    // Stop bits flipped mid-frame take effect only after COMMIT
    cfg_parity_en_i = 1'b0;
    cfg_stop_bits_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    chk("t4_stop_before", rx_stop_bits_o, 0);
    frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i); chk("t4_stop_recv", rx_stop_bits_o, 0);
    @(negedge clk_i); chk("t4_stop_commit", rx_stop_bits_o, 0);
    @(negedge clk_i); chk("t4_stop_armed", rx_stop_bits_o, 0);
    @(negedge clk_i); chk("t4_stop_after", rx_stop_bits_o, 1);

    // Six good frames into a depth-4 FIFO with no consumer
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'h11 * 8'(i + 1);
      frame(b, 1'b0, 1'b0, (i < 4) ? 1'b1 : 1'b0, 1'b0);
    end
    repeat (3) @(negedge clk_i);
    chk("t3_level_full", fifo_level_o, 4);
    chk("t3_overflow", overflow_o, 1);
    chk("t3_head", m_data_o, 8'h11);
    m_ready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("t3_level_drained", fifo_level_o, 0);
    chk("t3_sb_empty", sb.size(), 0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("t3_clr", {overflow_o, parity_cnt_o, framing_cnt_o}, 0);

    // Full FIFO with push and pop on the same cycle: no overflow
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame(8'h81 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    frame(8'h85, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t3b_level", fifo_level_o, 4);
    chk("t3b_no_overflow", overflow_o, 0);
    m_ready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("t3b_drained", fifo_level_o, 0);
    chk("t3b_sb_empty", sb.size(), 0);

    // Reset in the middle of a frame
    m_ready_i = 1'b0;
    cfg_parity_en_i = 1'b1;
    frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    chk("t6_pre_level", fifo_level_o, 1);
    chk("t6_pre_parity", parity_cnt_o, 1);
    repeat (3) tick();
    rx_data_i = 8'h99;
    rx_busy_i = 1'b1;
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("t6_enable", rx_enable_o, 0);
    chk("t6_cfg", {rx_parity_en_o, rx_parity_sel_o, rx_stop_bits_o}, 0);
    chk("t6_fifo", {m_valid_o, m_data_o, fifo_level_o}, 0);
    chk("t6_flags", {overflow_o, timeout_o, parity_cnt_o, framing_cnt_o}, 0);
    tick();
    rst_i = 1'b0;
    repeat (4) tick();
    @(negedge clk_i);
    chk("t6_off_busy", rx_enable_o, 0);
    chk("t6_cfg_held", rx_parity_en_o, 0);
    tick();
    rx_busy_i = 1'b0;
    m_ready_i = 1'b1;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (m_valid_o) hits++;
    end
    chk("t6_no_commit", hits, 0);
    chk("t6_level", fifo_level_o, 0);
    chk("t6_rearmed", {rx_enable_o, rx_parity_en_o}, 2'b11);
    chk("end_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
